// File: rtl/br_dump_ctrl_pkg.sv
// br_dump_ctrl_pkg: shared BR geometry, dump FSM state encodings and stream word type.
// The optional clear pass (BR_DUMP_CLEAR_EN) reuses ST_CLEAR from here.
package br_dump_ctrl_pkg;

   localparam int BR_AW    = 5;
   localparam int BR_DW    = 32;
   localparam int BR_NREGS = 32;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_READ  = 3'd1;
   localparam logic [2:0] ST_HOLD  = 3'd2;
   localparam logic [2:0] ST_CLEAR = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;

   typedef struct packed {
      logic [BR_AW-1:0] addr;
      logic [BR_DW-1:0] data;
   } br_word_t;

endpackage

// File: rtl/br_dump_ctrl_if.sv
// br_dump_ctrl_if: valid/ready stream carrying one {addr,data} register word per beat.
interface br_dump_ctrl_if
   import br_dump_ctrl_pkg::*;
#(
   parameter int AW = BR_AW,
   parameter int DW = BR_DW
) ();

   logic          m_valid;
   logic          m_ready;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_data;

   modport master (output m_valid, output m_addr, output m_data, input  m_ready);
   modport slave  (input  m_valid, input  m_addr, input  m_data, output m_ready);

endinterface

// File: rtl/br_dump_ctrl_ptr_cnt.sv
// br_dump_ctrl_ptr_cnt: register pointer shared by the read sweep and the clear sweep.
// Clear wins over the held value and inc is added on top, so clr+inc loads 1.
module br_dump_ctrl_ptr_cnt
   import br_dump_ctrl_pkg::*;
#(
   parameter int AW    = BR_AW,
   parameter int NREGS = BR_NREGS
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_clr,
   input  logic          i_inc,
   output logic [AW-1:0] o_ptr,
   output logic          o_last
);

   logic [AW-1:0] r_ptr;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr <= '0;
      end else if (i_clr || i_inc) begin
         r_ptr <= (i_clr ? '0 : r_ptr) + AW'(i_inc);
      end
   end

   assign o_ptr  = r_ptr;
   assign o_last = (r_ptr == AW'(NREGS - 1));

endmodule

// File: rtl/br_dump_ctrl.sv
// br_dump_ctrl: on start, reads every BR register through port 1 and streams {addr,data}.
// Defining BR_DUMP_CLEAR_EN adds a clear pass zeroing x1..x(NREGS-1) after the dump.
module br_dump_ctrl
   import br_dump_ctrl_pkg::*;
#(
   parameter int NREGS = BR_NREGS,
   parameter int AW    = BR_AW,
   parameter int DW    = BR_DW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   output logic          busy,
   output logic          done,
   output logic [AW-1:0] br_a1,
   input  logic [DW-1:0] br_rd1,
   output logic [AW-1:0] br_a3,
   output logic [DW-1:0] br_wd3,
   output logic          br_we3,
   br_dump_ctrl_if.master m_if
);

`ifdef BR_DUMP_CLEAR_EN
   localparam logic [2:0] ST_AFTER_DUMP = ST_CLEAR;
   localparam logic       CLEAR_EN      = 1'b1;
`else
   localparam logic [2:0] ST_AFTER_DUMP = ST_DONE;
   localparam logic       CLEAR_EN      = 1'b0;
`endif

   logic [2:0]    r_state;
   logic          r_valid;
   logic [AW-1:0] r_addr;
   logic [DW-1:0] r_data;
   logic [AW-1:0] w_ptr;
   logic          w_last;
   logic          w_hs;
   logic          w_clr;
   logic          w_inc;

   // m_valid is always high in HOLD, so ready alone completes the handshake there.
   assign w_hs  = (r_state == ST_HOLD) && m_if.m_ready;
   assign w_clr = ((r_state == ST_IDLE) && start) || (w_hs && w_last)
                  || ((r_state == ST_CLEAR) && w_last);
   assign w_inc = (w_hs && (!w_last || CLEAR_EN)) || ((r_state == ST_CLEAR) && !w_last);

   br_dump_ctrl_ptr_cnt #(.AW(AW), .NREGS(NREGS)) u_ptr (
      .clk    (clk),
      .rst    (rst),
      .i_clr  (w_clr),
      .i_inc  (w_inc),
      .o_ptr  (w_ptr),
      .o_last (w_last)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_valid <= 1'b0;
         r_addr  <= '0;
         r_data  <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) r_state <= ST_READ;
            end
            ST_READ: begin
               r_valid <= 1'b1;
               r_addr  <= w_ptr;
               r_data  <= br_rd1;
               r_state <= ST_HOLD;
            end
            ST_HOLD: begin
               if (m_if.m_ready) begin
                  r_valid <= 1'b0;
                  r_state <= w_last ? ST_AFTER_DUMP : ST_READ;
               end
            end
`ifdef BR_DUMP_CLEAR_EN
            ST_CLEAR: begin
               if (w_last) r_state <= ST_DONE;
            end
`endif
            ST_DONE: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy         = (r_state != ST_IDLE);
   assign done         = (r_state == ST_DONE);
   assign br_a1        = (r_state == ST_READ) ? w_ptr : '0;
   assign m_if.m_valid = r_valid;
   assign m_if.m_addr  = r_addr;
   assign m_if.m_data  = r_data;

`ifdef BR_DUMP_CLEAR_EN
   assign br_we3 = (r_state == ST_CLEAR);
   assign br_a3  = br_we3 ? w_ptr : '0;
`else
   assign br_we3 = 1'b0;
   assign br_a3  = '0;
`endif
   assign br_wd3 = '0;

endmodule
